// File: rtl/cpu_pkg.sv
// cpu_pkg: control-word bit map, flag indices and opcodes shared with the control unit
package cpu_pkg;
   localparam int DATA_W_DEF   = 16;
   localparam int SHAMT_W_DEF  = 4;
   localparam int CS_MBR2BR    = 6;
   localparam int CS_MBR2ACC   = 10;
   localparam int CS_ACC_CLEAR = 21;
   localparam int CS_ADD       = 22;
   localparam int CS_SUB       = 23;
   localparam int CS_AND       = 24;
   localparam int CS_OR        = 25;
   localparam int CS_NOT       = 26;
   localparam int CS_LSL       = 27;
   localparam int CS_LSR       = 28;
   localparam int CS_MPY       = 29;
   localparam int CS_ASL       = 30;
   localparam int CS_ASR       = 31;
   localparam int NUM_OPS      = CS_ASR - CS_ADD + 1;
   localparam int FL_SIGN      = 0;
   localparam int FL_ZERO      = 1;
   localparam int FL_CARRY     = 2;
   localparam int FL_OVF       = 3;
   localparam int FL_ILL       = 4;
   // encoding order follows control-bit order so the priority encoder can index it
   typedef enum logic [3:0] {
      OP_NONE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_LSL, OP_LSR, OP_MPY, OP_ASL, OP_ASR
   } alu_op_e;
   typedef enum logic [1:0] {MPY_IDLE, MPY_RUN, MPY_DONE} mpy_state_e;
endpackage

// File: rtl/mpy_seq.sv
// mpy_seq: unsigned shift-add multiplier, one partial product per clock
module mpy_seq
   import cpu_pkg::*;
#(
   parameter int W = DATA_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           abort,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);
   localparam int CW = $clog2(W);
   mpy_state_e state_q, state_d;
   logic [2*W-1:0] mcand_q, mcand_d, prod_q, prod_d;
   logic [W-1:0] mplier_q, mplier_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      case (state_q)
         MPY_IDLE: if (start) begin
            state_d  = MPY_RUN;
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
         end
         MPY_RUN: begin
            prod_d  = prod_q + (mplier_q[cnt_q] ? mcand_q << cnt_q : '0);
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(W - 1)) ? MPY_DONE : MPY_RUN;
         end
         default: state_d = MPY_IDLE;
      endcase
      if (abort) state_d = MPY_IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MPY_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
      end
   end
   assign busy    = state_q != MPY_IDLE;
   assign done    = state_q == MPY_DONE;
   assign product = prod_q;
endmodule

// File: rtl/alu_acc_unit.sv
// alu_acc_unit: ACC/BR/MR datapath executing edge-qualified ALU micro-operations
module alu_acc_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SHAMT_W = SHAMT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       control_signal,
   input  logic [DATA_W-1:0] mbr_in,
   output logic [DATA_W-1:0] acc_out,
   output logic [DATA_W-1:0] mr_out,
   output logic [7:0]        flags,
   output logic              busy
);
   localparam int M = DATA_W - 1;
   logic [31:0] prev_cs_q, prev_cs_d, rise;
   logic [DATA_W-1:0] acc_q, acc_d, br_q, br_d, mr_q, mr_d, acc_e, res;
   logic [DATA_W:0] sum, dif;
   logic [4:0] flags_q, flags_d;
   logic [NUM_OPS-1:0] ops;
   logic [SHAMT_W-1:0] sh;
   logic [2*DATA_W-1:0] product;
   alu_op_e op;
   logic clr, multi, res_c, res_v, asl_v, wr, start, abort, m_done, unused_rise;
   assign rise        = control_signal & ~prev_cs_q;
   assign ops         = rise[CS_ASR:CS_ADD];
   assign clr         = rise[CS_ACC_CLEAR];
   assign multi       = |(ops & (ops - NUM_OPS'(1)));
   assign acc_e       = clr ? '0 : acc_q;
   assign sh          = br_q[SHAMT_W-1:0];
   assign unused_rise = ^{rise[CS_ACC_CLEAR-1:CS_MBR2ACC+1], rise[CS_MBR2ACC-1:CS_MBR2BR+1], rise[CS_MBR2BR-1:0]};
   mpy_seq #(.W(DATA_W)) u_mpy (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .a(acc_e), .b(br_q),
      .busy(busy), .done(m_done), .product(product)
   );
   always_comb begin
      op = OP_NONE;
      for (int i = NUM_OPS - 1; i >= 0; i--) if (ops[i]) op = alu_op_e'(4'(i + 1));
   end
   // asl overflows when any bit shifted through the sign position differs from its neighbour
   always_comb begin
      asl_v = 1'b0;
      for (int i = 1; i < DATA_W; i++) asl_v = asl_v | ((i <= int'(sh)) && (acc_e[DATA_W-i] != acc_e[M-i]));
   end
   always_comb begin
      sum   = {1'b0, acc_e} + {1'b0, br_q};
      dif   = {1'b0, acc_e} - {1'b0, br_q};
      res   = acc_e;
      res_c = 1'b0;
      res_v = 1'b0;
      case (op)
         OP_ADD: begin
            {res_c, res} = sum;
            res_v = (acc_e[M] == br_q[M]) && (sum[M] != acc_e[M]);
         end
         OP_SUB: begin
            {res_c, res} = dif;
            res_v = (acc_e[M] != br_q[M]) && (dif[M] != acc_e[M]);
         end
         OP_AND: res = acc_e & br_q;
         OP_OR:  res = acc_e | br_q;
         OP_NOT: res = ~br_q;
         OP_LSL: res = acc_e << sh;
         OP_LSR: res = acc_e >> sh;
         OP_ASL: begin
            res   = acc_e << sh;
            res_v = asl_v;
         end
         OP_ASR: res = $unsigned($signed(acc_e) >>> sh);
         default: ;
      endcase
   end
   always_comb begin
      prev_cs_d = control_signal;
      br_d      = rise[CS_MBR2BR] ? mbr_in : br_q;
      acc_d     = acc_q;
      mr_d      = mr_q;
      flags_d   = flags_q;
      wr        = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      if (busy) begin
         flags_d[FL_ILL] = flags_q[FL_ILL] | (|ops) | rise[CS_MBR2ACC];
         if (clr) begin
            abort = 1'b1;
            acc_d = '0;
            wr    = 1'b1;
         end else if (m_done) begin
            acc_d             = product[2*DATA_W-1:DATA_W];
            mr_d              = product[M:0];
            flags_d[FL_CARRY] = 1'b0;
            flags_d[FL_OVF]   = |product[2*DATA_W-1:DATA_W];
            wr                = 1'b1;
         end
      end else begin
         flags_d[FL_ILL] = flags_q[FL_ILL] | multi;
         if (op == OP_MPY) begin
            start = 1'b1;
            acc_d = acc_e;
            wr    = clr;
         end else if (op != OP_NONE) begin
            acc_d             = res;
            flags_d[FL_CARRY] = res_c;
            flags_d[FL_OVF]   = res_v;
            wr                = 1'b1;
         end else if (rise[CS_MBR2ACC]) begin
            acc_d = mbr_in;
            wr    = 1'b1;
         end else if (clr) begin
            acc_d = '0;
            wr    = 1'b1;
         end
      end
      if (wr) begin
         flags_d[FL_SIGN] = acc_d[M];
         flags_d[FL_ZERO] = acc_d == '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_cs_q <= '0;
         acc_q     <= '0;
         br_q      <= '0;
         mr_q      <= '0;
         flags_q   <= '0;
      end else begin
         prev_cs_q <= prev_cs_d;
         acc_q     <= acc_d;
         br_q      <= br_d;
         mr_q      <= mr_d;
         flags_q   <= flags_d;
      end
   end
   assign acc_out = acc_q;
   assign mr_out  = mr_q;
   assign flags   = {3'b000, flags_q};
endmodule

// File: tb/tb_alu_acc_unit.sv
// tb_alu_acc_unit: vector table, reference-model random words and multiply corner sequences
module tb_alu_acc_unit;
   localparam logic [31:0] C_BR  = 32'h0000_0040;
   localparam logic [31:0] C_ACC = 32'h0000_0400;
   localparam logic [31:0] C_CLR = 32'h0020_0000;
   localparam logic [31:0] C_ADD = 32'h0040_0000;
   localparam logic [31:0] C_SUB = 32'h0080_0000;
   localparam logic [31:0] C_AND = 32'h0100_0000;
   localparam logic [31:0] C_OR  = 32'h0200_0000;
   localparam logic [31:0] C_NOT = 32'h0400_0000;
   localparam logic [31:0] C_LSL = 32'h0800_0000;
   localparam logic [31:0] C_LSR = 32'h1000_0000;
   localparam logic [31:0] C_MPY = 32'h2000_0000;
   localparam logic [31:0] C_ASL = 32'h4000_0000;
   localparam logic [31:0] C_ASR = 32'h8000_0000;
   localparam logic [31:0] IGN   = 32'h001F_FBBF;
   typedef struct {
      logic [31:0] cs;
      logic [15:0] mbr;
      logic [15:0] acc;
      logic [7:0]  flg;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1, busy;
   logic [31:0] control_signal = '0;
   logic [15:0] mbr_in = '0, acc_out, mr_out;
   logic [7:0] flags;
   int errors = 0, checks = 0;
   vec_t tbl[26];
   logic [15:0] m_acc, m_br, m_mr;
   logic [7:0] m_flags;
   logic [31:0] m_prev;
   alu_acc_unit dut (
      .clk(clk), .rst(rst), .control_signal(control_signal), .mbr_in(mbr_in),
      .acc_out(acc_out), .mr_out(mr_out), .flags(flags), .busy(busy)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask
   task automatic drive(input logic [31:0] cs, input logic [15:0] mbr);
      control_signal = cs;
      mbr_in = mbr;
      repeat (2) @(negedge clk);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      control_signal = '0;
      @(negedge clk);
      rst = 1'b0;
      m_acc = '0; m_br = '0; m_mr = '0; m_flags = '0; m_prev = '0;
   endtask
   // reference: integer arithmetic on the rising bits of each held word (multiply excluded)
   task automatic model_word(input logic [31:0] cs, input logic [15:0] mbr);
      logic [31:0] r;
      logic [15:0] a, b, x, res;
      logic c, v, wr;
      int s, u, k, n, sh;
      r = cs & ~m_prev;
      m_prev = cs;
      a = r[21] ? 16'h0 : m_acc;
      b = m_br;
      sh = int'(b[3:0]);
      if (r[6]) m_br = mbr;
      k = -1; n = 0;
      for (int i = 22; i < 32; i++) if (r[i]) begin n++; if (k < 0) k = i; end
      if (n > 1) m_flags[4] = 1'b1;
      c = 1'b0; v = 1'b0; wr = 1'b1; res = a;
      case (k)
         22: begin
            u = int'(a) + int'(b); s = int'($signed(a)) + int'($signed(b));
            res = 16'(u); c = u > 65535; v = s > 32767 || s < -32768;
         end
         23: begin
            s = int'($signed(a)) - int'($signed(b));
            res = a - b; c = a < b; v = s > 32767 || s < -32768;
         end
         24: res = a & b;
         25: res = a | b;
         26: res = ~b;
         27: res = a << sh;
         28: res = a >> sh;
         30: begin
            x = a;
            for (int i = 0; i < sh; i++) begin
               if (x[15] != x[14]) v = 1'b1;
               x = x << 1;
            end
            res = x;
         end
         31: res = 16'($signed(a) >>> sh);
         default: if (r[10]) res = mbr; else if (r[21]) res = 16'h0; else wr = 1'b0;
      endcase
      if (wr) begin
         m_acc = res;
         m_flags[0] = res[15];
         m_flags[1] = res == 16'h0;
         if (k >= 0) begin m_flags[2] = c; m_flags[3] = v; end
      end
   endtask
   task automatic run_mpy(output int lat, output int bc, output logic stable);
      logic [15:0] a0;
      a0 = acc_out; lat = 0; bc = 0; stable = 1'b1;
      control_signal = C_MPY;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         @(negedge clk);
         if (busy) begin
            bc++;
            if (acc_out !== a0) stable = 1'b0;
         end else if (bc > 0) lat = i;
      end
      control_signal = '0;
      @(negedge clk);
   endtask
   initial begin
      int lat, bc, opi[9];
      logic stable;
      logic [31:0] w, pw, p;
      logic [15:0] mbr, ma, mb;
      logic [15:0] pa[8], pb[8];
      opi = '{22, 23, 24, 25, 26, 27, 28, 30, 31};
      tbl[0]  = '{C_BR | C_CLR, 16'h0005, 16'h0000, 8'h02};
      tbl[1]  = '{C_ADD,        16'h0005, 16'h0005, 8'h00};
      tbl[2]  = '{C_ACC,        16'h7FFF, 16'h7FFF, 8'h00};
      tbl[3]  = '{C_BR,         16'h0001, 16'h7FFF, 8'h00};
      tbl[4]  = '{C_ADD,        16'h0000, 16'h8000, 8'h09};
      tbl[5]  = '{C_BR,         16'h8000, 16'h8000, 8'h09};
      tbl[6]  = '{C_SUB,        16'h0000, 16'h0000, 8'h02};
      tbl[7]  = '{C_ACC,        16'h8001, 16'h8001, 8'h01};
      tbl[8]  = '{C_BR,         16'h0001, 16'h8001, 8'h01};
      tbl[9]  = '{C_ASR,        16'h0000, 16'hC000, 8'h01};
      tbl[10] = '{C_ACC,        16'h8001, 16'h8001, 8'h01};
      tbl[11] = '{C_LSR,        16'h0000, 16'h4000, 8'h00};
      tbl[12] = '{C_ACC,        16'h8001, 16'h8001, 8'h01};
      tbl[13] = '{C_ASL,        16'h0000, 16'h0002, 8'h08};
      tbl[14] = '{C_NOT,        16'h0000, 16'hFFFE, 8'h01};
      tbl[15] = '{C_BR,         16'h00F0, 16'hFFFE, 8'h01};
      tbl[16] = '{C_ACC,        16'h0F0F, 16'h0F0F, 8'h00};
      tbl[17] = '{C_OR | C_BR,  16'hAAAA, 16'h0FFF, 8'h00};
      tbl[18] = '{C_AND,        16'h0000, 16'h0AAA, 8'h00};
      tbl[19] = '{C_LSL,        16'h0000, 16'hA800, 8'h01};
      tbl[20] = '{C_ACC,        16'hFFFF, 16'hFFFF, 8'h01};
      tbl[21] = '{C_BR,         16'h0001, 16'hFFFF, 8'h01};
      tbl[22] = '{C_ADD,        16'h0000, 16'h0000, 8'h06};
      tbl[23] = '{C_SUB,        16'h0000, 16'hFFFF, 8'h05};
      tbl[24] = '{C_CLR | C_ADD, 16'h0000, 16'h0001, 8'h00};
      tbl[25] = '{C_SUB | C_AND, 16'h0000, 16'h0000, 8'h12};
      pa = '{16'h0007, 16'hFFFF, 16'h8000, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0};
      pb = '{16'h0009, 16'hFFFF, 16'h0002, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0};
      for (int i = 4; i < 8; i++) begin pa[i] = 16'($urandom); pb[i] = 16'($urandom); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_acc", acc_out, 0);
      chk("reset_mr", mr_out, 0);
      chk("reset_flags", flags, 0);
      chk("reset_busy", busy, 0);
      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].cs, tbl[i].mbr);
         chk($sformatf("vec%0d_acc", i), acc_out, tbl[i].acc);
         chk($sformatf("vec%0d_flags", i), flags, tbl[i].flg);
      end
      do_reset();
      pw = '0;
      for (int t = 0; t < 80; t++) begin
         if (t > 0 && $urandom_range(0, 4) == 0) w = pw;
         else if ($urandom_range(0, 5) == 0) w = C_ACC | ($urandom_range(0, 1) ? C_BR : 32'h0);
         else begin
            w = 32'h1 << opi[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 1) w |= C_BR;
            if ($urandom_range(0, 6) == 0) w |= C_CLR;
            if ($urandom_range(0, 19) == 0) w |= 32'h1 << opi[$urandom_range(0, 8)];
         end
         w |= $urandom & IGN;
         mbr = 16'($urandom);
         model_word(w, mbr);
         drive(w, mbr);
         chk($sformatf("rnd%0d_acc", t), acc_out, m_acc);
         chk($sformatf("rnd%0d_flags", t), flags, m_flags);
         chk($sformatf("rnd%0d_mr", t), mr_out, m_mr);
         pw = w;
      end
      do_reset();
      drive(C_ACC, 16'h0123);
      drive(C_BR, 16'h1000);
      run_mpy(lat, bc, stable);
      chk("mpy_latency", lat, 18);
      chk("mpy_busy_cycles", bc, 17);
      chk("mpy_acc_hold", stable, 1);
      chk("mpy_acc", acc_out, 16'h0012);
      chk("mpy_mr", mr_out, 16'h3000);
      chk("mpy_flags", flags, 8'h08);
      chk("mpy_busy_after", busy, 0);
      drive(C_MPY, 16'h0);
      chk("restart_busy", busy, 1);
      drive(C_ADD, 16'h0);
      chk("drop_acc", acc_out, 16'h0012);
      chk("drop_ill", flags[4], 1);
      chk("drop_busy", busy, 1);
      drive(C_CLR, 16'h0);
      chk("abort_acc", acc_out, 0);
      chk("abort_busy", busy, 0);
      chk("abort_mr", mr_out, 16'h3000);
      control_signal = '0;
      repeat (25) @(negedge clk);
      chk("abort_late_acc", acc_out, 0);
      chk("abort_late_mr", mr_out, 16'h3000);
      drive(C_ACC, 16'h0005);
      chk("ill_sticky", flags[4], 1);
      chk("ill_sticky_acc", acc_out, 16'h0005);
      drive(C_BR, 16'h0003);
      control_signal = C_MPY;
      repeat (5) @(negedge clk);
      chk("run_busy", busy, 1);
      rst = 1'b1;
      control_signal = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_run_acc", acc_out, 0);
      chk("rst_run_mr", mr_out, 0);
      chk("rst_run_flags", flags, 0);
      chk("rst_run_busy", busy, 0);
      repeat (20) @(negedge clk);
      chk("rst_run_late_acc", acc_out, 0);
      chk("rst_run_late_busy", busy, 0);
      for (int i = 0; i < 8; i++) begin
         ma = pa[i]; mb = pb[i];
         p = {16'h0, ma} * {16'h0, mb};
         drive(C_ACC, ma);
         drive(C_BR, mb);
         run_mpy(lat, bc, stable);
         chk($sformatf("pmpy%0d_lat", i), lat, 18);
         chk($sformatf("pmpy%0d_acc", i), acc_out, p[31:16]);
         chk($sformatf("pmpy%0d_mr", i), mr_out, p[15:0]);
         chk($sformatf("pmpy%0d_flags", i), flags, {4'b0, p[31:16] != 16'h0, 1'b0, p[31:16] == 16'h0, p[31]});
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
